// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and cache-side signal bundle for the load/store unit
interface load_store_unit_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] ALUResult;
   logic [WIDTH-1:0] WriteData;
   logic             MemRead;
   logic             MemWrite;
   logic [2:0]       Funct3;
   logic             Stall;
   logic [WIDTH-1:0] ReadData;
   logic             AccessErr;
   logic             MemReq;
   logic             MemWe;
   logic [WIDTH-1:0] MemAddr;
   logic [WIDTH-1:0] MemWData;
   logic [3:0]       MemByteEn;
   logic             MemReady;
   logic [WIDTH-1:0] MemRData;

   modport master (
      input  ALUResult, WriteData, MemRead, MemWrite, Funct3, MemReady, MemRData,
      output Stall, ReadData, AccessErr, MemReq, MemWe, MemAddr, MemWData, MemByteEn
   );

   modport slave (
      output ALUResult, WriteData, MemRead, MemWrite, Funct3, MemReady, MemRData,
      input  Stall, ReadData, AccessErr, MemReq, MemWe, MemAddr, MemWData, MemByteEn
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: aligned byte/half/word loads and stores over req/ready
// Three-state IDLE/BUSY/DONE sequencer; Mem* outputs are latched on accept and held through BUSY.
module load_store_unit #(
   parameter int WIDTH = 32
) (
   input  logic               CLK,
   input  logic               RST,
   load_store_unit_if.master  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic             req;
   logic             is_store;
   logic             illegal;
   logic             accept;
   logic             reject;
   logic [1:0]       off;
   logic [WIDTH-1:0] wdata_next;
   logic [3:0]       be_next;

   logic [WIDTH-1:0] addr_q;
   logic             we_q;
   logic [WIDTH-1:0] wdata_q;
   logic [3:0]       be_q;
   logic [1:0]       off_q;
   logic [2:0]       size_q;
   logic [WIDTH-1:0] rdata_q;
   logic             err_q;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] load_ext;

   assign req      = bus.MemWrite | bus.MemRead;
   assign is_store = bus.MemWrite;
   assign off      = bus.ALUResult[1:0];

   always_comb begin
      illegal = 1'b0;
      case (bus.Funct3)
         3'b000, 3'b100: illegal = 1'b0;
         3'b001, 3'b101: illegal = bus.ALUResult[0];
         3'b010:         illegal = (off != 2'b00);
         default:        illegal = 1'b1;
      endcase
      // Unsigned sizes only make sense for loads
      if (is_store && bus.Funct3[2])
         illegal = 1'b1;
   end

   assign accept = (state == IDLE) && req && !illegal;
   assign reject = (state == IDLE) && req && illegal;

   always_comb begin
      wdata_next = bus.WriteData;
      be_next    = 4'b1111;
      if (is_store) begin
         case (bus.Funct3[1:0])
            2'b00: begin
               wdata_next = {(WIDTH/8){bus.WriteData[7:0]}};
               be_next    = 4'b0001 << off;
            end
            2'b01: begin
               wdata_next = {(WIDTH/16){bus.WriteData[15:0]}};
               be_next    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
               wdata_next = bus.WriteData;
               be_next    = 4'b1111;
            end
         endcase
      end
   end

   assign shifted = bus.MemRData >> {off_q, 3'b000};

   always_comb begin
      load_ext = shifted;
      case (size_q)
         3'b000:  load_ext = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         3'b001:  load_ext = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         3'b100:  load_ext = {{(WIDTH-8){1'b0}}, shifted[7:0]};
         3'b101:  load_ext = {{(WIDTH-16){1'b0}}, shifted[15:0]};
         default: load_ext = shifted;
      endcase
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (bus.MemReady) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         be_q    <= 4'b0000;
         off_q   <= 2'b00;
         size_q  <= 3'b000;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         err_q <= reject;
         if (accept) begin
            addr_q  <= {bus.ALUResult[WIDTH-1:2], 2'b00};
            we_q    <= is_store;
            wdata_q <= wdata_next;
            be_q    <= be_next;
            off_q   <= off;
            size_q  <= bus.Funct3;
         end
         if (reject)
            rdata_q <= '0;
         else if (state == BUSY && bus.MemReady && !we_q)
            rdata_q <= load_ext;
      end
   end

   // MemReq comes straight off the state register so it never glitches
   assign bus.MemReq    = (state == BUSY);
   assign bus.Stall     = accept || (state == BUSY);
   assign bus.MemWe     = we_q;
   assign bus.MemAddr   = addr_q;
   assign bus.MemWData  = wdata_q;
   assign bus.MemByteEn = be_q;
   assign bus.ReadData  = rdata_q;
   assign bus.AccessErr = err_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage directly downstream of the ALU. It takes the ALU result as the effective address, issues byte, halfword or word loads and stores to the data cache over a req/ready handshake, and stalls the core until the access completes. Load data is aligned and sign- or zero-extended before it goes to the register-file writeback mux.

## Interface
Parameters:
- WIDTH, 32: data/address width; byte-lane logic is fixed at 4 lanes.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- ALUResult  in  WIDTH  effective address from the ALU.
- WriteData  in  WIDTH  store data (rs2).
- MemRead  in  1  load request from the main decoder.
- MemWrite  in  1  store request; has priority if MemRead is also high.
- Funct3  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores accept only 000/001/010.
- Stall  out  1  holds PC and pipeline registers while high.
- ReadData  out  WIDTH  registered, extended load result.
- AccessErr  out  1  one-cycle pulse on a misaligned or illegal-size access.
- MemReq  out  1  cache request.
- MemWe  out  1  1 = write.
- MemAddr  out  WIDTH  word-aligned address; bits [1:0] are always 0.
- MemWData  out  WIDTH  lane-replicated store data.
- MemByteEn  out  4  byte-lane enables.
- MemReady  in  1  cache completion; MemRData is valid in the same cycle.
- MemRData  in  WIDTH  raw word read from the cache.

## Operation
- FSM has three states: IDLE, BUSY, DONE. Reset puts it in IDLE.
- IDLE, legal request present:
  - latch MemAddr = {ALUResult[WIDTH-1:2], 2'b00}, MemWe, MemWData, MemByteEn, and the offset/size/sign for the load;
  - go to BUSY.
- IDLE, illegal request (the FSM stays in IDLE, MemReq stays 0, no stall):
  - AccessErr = 1 next cycle;
  - ReadData = 0.
- Illegal means any of:
  - H/HU with ALUResult[0] = 1;
  - W with ALUResult[1:0] != 0;
  - Funct3 ∈ {011, 110, 111};
  - a store with Funct3[2] = 1.
- BUSY:
  - MemReq = 1, and all Mem* outputs are held stable;
  - on MemReady, capture the extended load result into ReadData (a store leaves ReadData unchanged) and go to DONE.
- DONE: Stall = 0, so the core retires the instruction at the end of this cycle. Inputs are ignored. Next state is IDLE unconditionally.
- Store lane mapping:
  - SB: MemWData = {4{WriteData[7:0]}}, MemByteEn = 4'b0001 << ALUResult[1:0].
  - SH: MemWData = {2{WriteData[15:0]}}, MemByteEn = ALUResult[1] ? 4'b1100 : 4'b0011.
  - SW: MemWData = WriteData, MemByteEn = 4'b1111.
- Loads: MemByteEn = 4'b1111. The selected byte/halfword is MemRData >> (8·offset), then sign-extended (B, H) or zero-extended (BU, HU).
- MemWrite and MemRead both high: treated as a store.
- MemReady in IDLE or DONE is ignored.

## Timing
- Stall is combinational: 1 when (IDLE and a legal request is present) or BUSY; otherwise 0.
- MemReq is decoded from the state register and is glitch-free.
- Minimum access takes 3 cycles:
  - cycle 0: IDLE, Stall = 1;
  - cycle 1: BUSY, MemReq = 1, MemReady = 1;
  - cycle 2: DONE, Stall = 0, ReadData valid.
- Each extra cycle without MemReady adds one cycle of BUSY.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE.
- ReadData holds its value until the next load completes or an AccessErr occurs.
- Reset values: ReadData 0, AccessErr 0, MemReq 0, MemWe 0, MemAddr 0, MemWData 0, MemByteEn 0. Stall is 0 whenever no request is present.
- Reset asserted mid-access (BUSY or DONE): the FSM returns to IDLE and MemReq drops immediately (asynchronously). The pending access is abandoned and ReadData is cleared.
- No timeout: BUSY waits indefinitely for MemReady.

## Test plan
- LW at ALUResult = 0x0000_0104, MemRData = 0xDEAD_BEEF, MemReady in the first BUSY cycle -> MemAddr = 0x104, MemByteEn = 1111, Stall high for 2 cycles, ReadData = 0xDEAD_BEEF in cycle 2.
- LB / LBU at offset 3 with MemRData = 0x80xx_xxxx -> ReadData = 0xFFFF_FF80 / 0x0000_0080. LH at offset 2 with MemRData = 0x8001_xxxx -> 0xFFFF_8001.
- SB at 0x0000_0011 with WriteData = 0x1234_56AB -> MemWe = 1, MemAddr = 0x10, MemByteEn = 0010, MemWData = 0xABAB_ABAB. SH at 0x...2 -> MemByteEn = 1100, MemWData = 0x56AB_56AB.
- LW at 0x0000_0102 -> no MemReq, Stall stays 0, AccessErr pulses 1 cycle, ReadData = 0. Repeat with Funct3 = 011 and with SW + Funct3 = 100 -> same response.
- MemReady withheld for 5 cycles -> BUSY for 5+1 cycles, Mem* outputs stable throughout, Stall high until DONE. Then a back-to-back SW is accepted in the following IDLE cycle.
- RST pulled low during BUSY -> MemReq = 0 within the same cycle, state returns to IDLE, all outputs at reset values. After release, a new LW completes normally.
